cdb_arbiter: RTL and testbench

- Shares the single common data bus (CDB) between two producers: the arithmetic/branch unit (src 0, ALU) and the load/store buffer (src 1, LSB).
- Each producer pushes results into a private FIFO. The arbiter pops one head per cycle round-robin and drives a registered CDB broadcast to the ROB and the reservation stations.
- It back-pressures producers with an early stall flag so registered producers never overflow.

---
 rtl/cdb_arbiter_pkg.sv | 21 ++
 rtl/cdb_arbiter_if.sv | 46 ++++
 rtl/cdb_arbiter_fifo.sv | 63 ++++++
 rtl/cdb_arbiter.sv | 147 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// Package : cdb_arbiter_pkg
// Desc    : Shared widths, depth and source encoding for the CDB arbiter.
// Rev     : 1.0  initial release
// ------------------------------------------------------------------
package cdb_arbiter_pkg;

    localparam int CDB_ROB_BIT    = 5;
    localparam int CDB_DAT_W      = 32;
    localparam int CDB_ADR_W      = 16;
    localparam int CDB_FIFO_DEPTH = 4;

    typedef enum logic {
        CDB_SRC_ALU = 1'b0,
        CDB_SRC_LSB = 1'b1
    } cdb_src_e;

endpackage

`default_nettype wire

// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// ------------------------------------------------------------------
// Interface : cdb_arbiter_if
// Desc      : Producer result inputs, stall flags and CDB broadcast bus.
// Rev       : 1.0  initial release
// ------------------------------------------------------------------
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int ROB_BIT = CDB_ROB_BIT,
    parameter int DAT_W   = CDB_DAT_W,
    parameter int ADR_W   = CDB_ADR_W
);
    logic               alu_en_i;
    logic [ROB_BIT-1:0] alu_q_i;
    logic [DAT_W-1:0]   alu_v_i;
    logic               alu_cbr_i;
    logic [ADR_W-1:0]   alu_cbt_i;
    logic               lsb_en_i;
    logic [ROB_BIT-1:0] lsb_q_i;
    logic [DAT_W-1:0]   lsb_v_i;
    logic               alu_stall_o;
    logic               lsb_stall_o;
    logic               cdb_en_o;
    logic [ROB_BIT-1:0] cdb_q_o;
    logic [DAT_W-1:0]   cdb_v_o;
    logic               cdb_cbr_o;
    logic [ADR_W-1:0]   cdb_cbt_o;
    logic               cdb_src_o;

    modport master (
        output alu_en_i, alu_q_i, alu_v_i, alu_cbr_i, alu_cbt_i,
        output lsb_en_i, lsb_q_i, lsb_v_i,
        input  alu_stall_o, lsb_stall_o,
        input  cdb_en_o, cdb_q_o, cdb_v_o, cdb_cbr_o, cdb_cbt_o, cdb_src_o
    );

    modport slave (
        input  alu_en_i, alu_q_i, alu_v_i, alu_cbr_i, alu_cbt_i,
        input  lsb_en_i, lsb_q_i, lsb_v_i,
        output alu_stall_o, lsb_stall_o,
        output cdb_en_o, cdb_q_o, cdb_v_o, cdb_cbr_o, cdb_cbt_o, cdb_src_o
    );
endinterface

`default_nettype wire

// File: rtl/cdb_arbiter_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// Module : cdb_fifo
// Desc   : Synchronous FIFO with flush and occupancy count, one per source.
// Rev    : 1.0  initial release
// ------------------------------------------------------------------
module cdb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  logic [WIDTH-1:0]       i_data,
    output logic [WIDTH-1:0]       o_data,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int c_aw = $clog2(DEPTH);
    localparam logic [c_aw:0] c_full = (c_aw + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr;
    logic [c_aw-1:0]  r_rd;
    logic [c_aw:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_do_pop  = i_pop  & ~i_flush & (r_count != '0);
    assign w_do_push = i_push & ~i_flush & ((r_count != c_full) | w_do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + c_aw'(1);
            if (w_do_pop)  r_rd <= r_rd + c_aw'(1);
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_aw + 1)'(1);
                2'b01:   r_count <= r_count - (c_aw + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr] <= i_data;
    end

    assign o_data  = r_mem[r_rd];
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// Module : cdb_arbiter
// Desc   : Round-robin sharing of the registered CDB between ALU and LSB.
// Rev    : 1.0  initial release
// ------------------------------------------------------------------
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH   = CDB_FIFO_DEPTH,
    parameter int ROB_BIT = CDB_ROB_BIT,
    parameter int DAT_W   = CDB_DAT_W,
    parameter int ADR_W   = CDB_ADR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr_i,
    cdb_arbiter_if.slave bus,
    output logic         ovf_o
);
    localparam int c_alu_w = ROB_BIT + DAT_W + 1 + ADR_W;
    localparam int c_lsb_w = ROB_BIT + DAT_W;
    localparam int c_cnt_w = $clog2(DEPTH) + 1;
    localparam logic [c_cnt_w-1:0] c_full      = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_stall_lvl = c_cnt_w'(DEPTH - 1);

    logic [c_alu_w-1:0] w_alu_head;
    logic [c_lsb_w-1:0] w_lsb_head;
    logic [c_cnt_w-1:0] w_alu_cnt;
    logic [c_cnt_w-1:0] w_lsb_cnt;
    logic               w_active;
    logic               w_flush;
    logic               w_alu_vld;
    logic               w_lsb_vld;
    logic               w_grant_vld;
    cdb_src_e           w_grant;
    logic               w_alu_pop;
    logic               w_lsb_pop;
    logic               w_alu_push;
    logic               w_lsb_push;
    logic               w_drop;

    logic               r_cdb_en;
    logic [ROB_BIT-1:0] r_cdb_q;
    logic [DAT_W-1:0]   r_cdb_v;
    logic               r_cdb_cbr;
    logic [ADR_W-1:0]   r_cdb_cbt;
    cdb_src_e           r_cdb_src;
    cdb_src_e           r_last_grant;
    logic               r_ovf;

    assign w_active   = en & ~clr_i;
    assign w_flush    = en & clr_i;
    assign w_alu_vld  = (w_alu_cnt != '0);
    assign w_lsb_vld  = (w_lsb_cnt != '0);
    assign w_alu_push = w_active & bus.alu_en_i;
    assign w_lsb_push = w_active & bus.lsb_en_i;

    always_comb begin
        w_grant_vld = w_alu_vld | w_lsb_vld;
        w_grant     = CDB_SRC_ALU;
        if (w_alu_vld && w_lsb_vld)
            w_grant = (r_last_grant == CDB_SRC_ALU) ? CDB_SRC_LSB : CDB_SRC_ALU;
        else if (w_lsb_vld)
            w_grant = CDB_SRC_LSB;
    end

    assign w_alu_pop = w_active & w_grant_vld & (w_grant == CDB_SRC_ALU);
    assign w_lsb_pop = w_active & w_grant_vld & (w_grant == CDB_SRC_LSB);
    assign w_drop    = (w_alu_push & (w_alu_cnt == c_full) & ~w_alu_pop) |
                       (w_lsb_push & (w_lsb_cnt == c_full) & ~w_lsb_pop);

    cdb_fifo #(.WIDTH(c_alu_w), .DEPTH(DEPTH)) u_alu_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_alu_push),
        .i_pop   (w_alu_pop),
        .i_flush (w_flush),
        .i_data  ({bus.alu_q_i, bus.alu_v_i, bus.alu_cbr_i, bus.alu_cbt_i}),
        .o_data  (w_alu_head),
        .o_count (w_alu_cnt)
    );

    cdb_fifo #(.WIDTH(c_lsb_w), .DEPTH(DEPTH)) u_lsb_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_lsb_push),
        .i_pop   (w_lsb_pop),
        .i_flush (w_flush),
        .i_data  ({bus.lsb_q_i, bus.lsb_v_i}),
        .o_data  (w_lsb_head),
        .o_count (w_lsb_cnt)
    );

    // last_grant resets to LSB so the first tie goes to the ALU.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cdb_en     <= 1'b0;
            r_cdb_q      <= '0;
            r_cdb_v      <= '0;
            r_cdb_cbr    <= 1'b0;
            r_cdb_cbt    <= '0;
            r_cdb_src    <= CDB_SRC_ALU;
            r_last_grant <= CDB_SRC_LSB;
            r_ovf        <= 1'b0;
        end else if (en) begin
            if (w_drop) r_ovf <= 1'b1;
            if (clr_i || !w_grant_vld) begin
                r_cdb_en  <= 1'b0;
                r_cdb_q   <= '0;
                r_cdb_v   <= '0;
                r_cdb_cbr <= 1'b0;
                r_cdb_cbt <= '0;
                r_cdb_src <= CDB_SRC_ALU;
                if (clr_i) r_last_grant <= CDB_SRC_LSB;
            end else begin
                r_cdb_en     <= 1'b1;
                r_cdb_src    <= w_grant;
                r_last_grant <= w_grant;
                if (w_grant == CDB_SRC_ALU) begin
                    {r_cdb_q, r_cdb_v, r_cdb_cbr, r_cdb_cbt} <= w_alu_head;
                end else begin
                    {r_cdb_q, r_cdb_v} <= w_lsb_head;
                    r_cdb_cbr          <= 1'b0;
                    r_cdb_cbt          <= '0;
                end
            end
        end else begin
            r_cdb_en <= 1'b0;
        end
    end

    // Stall one entry early so a producer reacting a cycle late never overflows.
    assign bus.alu_stall_o = (w_alu_cnt >= c_stall_lvl);
    assign bus.lsb_stall_o = (w_lsb_cnt >= c_stall_lvl);
    assign bus.cdb_en_o    = r_cdb_en;
    assign bus.cdb_q_o     = r_cdb_q;
    assign bus.cdb_v_o     = r_cdb_v;
    assign bus.cdb_cbr_o   = r_cdb_cbr;
    assign bus.cdb_cbt_o   = r_cdb_cbt;
    assign bus.cdb_src_o   = r_cdb_src;
    assign ovf_o           = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// Module : tb_cdb_arbiter
// Desc   : Self-checking bench: vector table, queue model, corner sequences.
// Rev    : 1.0  initial release
// ------------------------------------------------------------------
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int DEPTH   = CDB_FIFO_DEPTH;
    localparam int ROB_BIT = CDB_ROB_BIT;
    localparam int DAT_W   = CDB_DAT_W;
    localparam int ADR_W   = CDB_ADR_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;
    logic clr = 1'b0;
    logic ovf;

    cdb_arbiter_if #(.ROB_BIT(ROB_BIT), .DAT_W(DAT_W), .ADR_W(ADR_W)) bus ();

    cdb_arbiter #(.DEPTH(DEPTH), .ROB_BIT(ROB_BIT), .DAT_W(DAT_W), .ADR_W(ADR_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .clr_i (clr),
        .bus   (bus),
        .ovf_o (ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ROB_BIT-1:0] q;
        logic [DAT_W-1:0]   v;
        logic               cbr;
        logic [ADR_W-1:0]   cbt;
    } pay_t;

    typedef struct {
        logic en, clr, a_en;
        logic [ROB_BIT-1:0] a_q;
        logic [DAT_W-1:0]   a_v;
        logic               a_cbr;
        logic [ADR_W-1:0]   a_cbt;
        logic               l_en;
        logic [ROB_BIT-1:0] l_q;
        logic [DAT_W-1:0]   l_v;
        logic               x_en, x_src;
        logic [ROB_BIT-1:0] x_q;
    } vec_t;

    pay_t m_alu[$];
    pay_t m_lsb[$];
    logic m_last;
    logic m_ovf;
    logic e_en;
    logic e_src;
    pay_t e_pay;
    logic [ROB_BIT:0] bc_log[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_in(input bit ae, input int aq, input int av, input bit acbr, input int acbt,
                          input bit le, input int lq, input int lv);
        bus.alu_en_i  = ae;
        bus.alu_q_i   = ROB_BIT'(aq);
        bus.alu_v_i   = DAT_W'(av);
        bus.alu_cbr_i = acbr;
        bus.alu_cbt_i = ADR_W'(acbt);
        bus.lsb_en_i  = le;
        bus.lsb_q_i   = ROB_BIT'(lq);
        bus.lsb_v_i   = DAT_W'(lv);
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic model_reset();
        m_alu.delete();
        m_lsb.delete();
        m_last = 1'b1;
        m_ovf  = 1'b0;
        e_en   = 1'b0;
        e_src  = 1'b0;
        e_pay  = '0;
    endtask

    // Transaction model evaluated with the inputs present just before the edge.
    task automatic model_edge();
        pay_t a;
        pay_t l;
        logic av;
        logic lv;
        if (!en) begin
            e_en = 1'b0;
        end else if (clr) begin
            m_alu.delete();
            m_lsb.delete();
            e_en   = 1'b0;
            m_last = 1'b1;
        end else begin
            av = (m_alu.size() > 0);
            lv = (m_lsb.size() > 0);
            if (av || lv) begin
                if (av && (!lv || m_last)) begin
                    e_pay = m_alu.pop_front();
                    e_src = 1'b0;
                end else begin
                    e_pay = m_lsb.pop_front();
                    e_src = 1'b1;
                end
                e_en   = 1'b1;
                m_last = e_src;
            end else begin
                e_en = 1'b0;
            end
            if (bus.alu_en_i) begin
                a.q = bus.alu_q_i; a.v = bus.alu_v_i; a.cbr = bus.alu_cbr_i; a.cbt = bus.alu_cbt_i;
                if (m_alu.size() >= DEPTH) m_ovf = 1'b1;
                else m_alu.push_back(a);
            end
            if (bus.lsb_en_i) begin
                l.q = bus.lsb_q_i; l.v = bus.lsb_v_i; l.cbr = 1'b0; l.cbt = '0;
                if (m_lsb.size() >= DEPTH) m_ovf = 1'b1;
                else m_lsb.push_back(l);
            end
        end
    endtask

    task automatic compare_all();
        chk("cdb_en", bus.cdb_en_o, e_en);
        if (e_en) begin
            chk("cdb_q", bus.cdb_q_o, e_pay.q);
            chk("cdb_v", bus.cdb_v_o, e_pay.v);
            chk("cdb_cbr", bus.cdb_cbr_o, e_pay.cbr);
            chk("cdb_cbt", bus.cdb_cbt_o, e_pay.cbt);
            chk("cdb_src", bus.cdb_src_o, e_src);
        end
        chk("alu_stall", bus.alu_stall_o, m_alu.size() >= DEPTH - 1);
        chk("lsb_stall", bus.lsb_stall_o, m_lsb.size() >= DEPTH - 1);
        chk("ovf", ovf, m_ovf);
        if (bus.cdb_en_o) bc_log.push_back({bus.cdb_src_o, bus.cdb_q_o});
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic reset_dut();
        idle();
        en  = 1'b1;
        clr = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cdb_en", bus.cdb_en_o, 0);
        chk("rst_cdb_q", bus.cdb_q_o, 0);
        chk("rst_cdb_v", bus.cdb_v_o, 0);
        chk("rst_cdb_cbr", bus.cdb_cbr_o, 0);
        chk("rst_cdb_cbt", bus.cdb_cbt_o, 0);
        chk("rst_cdb_src", bus.cdb_src_o, 0);
        chk("rst_stalls", {bus.alu_stall_o, bus.lsb_stall_o}, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b1;
        model_reset();
        bc_log.delete();
    endtask

    function automatic vec_t mkv(input bit e, input bit c, input bit ae, input int aq, input int av,
                                 input bit acbr, input int acbt, input bit le, input int lq,
                                 input int lv, input bit xe, input bit xs, input int xq);
        vec_t r;
        r.en = e; r.clr = c; r.a_en = ae; r.a_q = ROB_BIT'(aq); r.a_v = DAT_W'(av);
        r.a_cbr = acbr; r.a_cbt = ADR_W'(acbt); r.l_en = le; r.l_q = ROB_BIT'(lq);
        r.l_v = DAT_W'(lv); r.x_en = xe; r.x_src = xs; r.x_q = ROB_BIT'(xq);
        return r;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vt[15];
        int   na;
        int   nl;
        int   nb;

        // Expected outputs are those visible just after each row's edge.
        vt[0]  = mkv(1,0, 1,3,'h1234,1,'h100, 0,0,0,     0,0,0);
        vt[1]  = mkv(1,0, 0,0,0,0,0,          0,0,0,     1,0,3);
        vt[2]  = mkv(1,0, 0,0,0,0,0,          0,0,0,     0,0,0);
        vt[3]  = mkv(1,1, 0,0,0,0,0,          0,0,0,     0,0,0);
        vt[4]  = mkv(1,0, 1,0,'h10,0,0,       1,8,'h80,  0,0,0);
        vt[5]  = mkv(1,0, 1,1,'h11,1,'h21,    1,9,'h81,  1,0,0);
        vt[6]  = mkv(1,0, 1,2,'h12,0,0,       1,10,'h82, 1,1,8);
        vt[7]  = mkv(0,0, 1,30,'h55,1,'h55,   1,31,'h66, 0,0,0);
        vt[8]  = mkv(0,0, 0,0,0,0,0,          0,0,0,     0,0,0);
        vt[9]  = mkv(0,1, 0,0,0,0,0,          0,0,0,     0,0,0);
        vt[10] = mkv(1,0, 0,0,0,0,0,          0,0,0,     1,0,1);
        vt[11] = mkv(1,0, 0,0,0,0,0,          0,0,0,     1,1,9);
        vt[12] = mkv(1,0, 0,0,0,0,0,          0,0,0,     1,0,2);
        vt[13] = mkv(1,0, 0,0,0,0,0,          0,0,0,     1,1,10);
        vt[14] = mkv(1,0, 0,0,0,0,0,          0,0,0,     0,0,0);

        reset_dut();
        for (int i = 0; i < 15; i++) begin
            en  = vt[i].en;
            clr = vt[i].clr;
            set_in(vt[i].a_en, int'(vt[i].a_q), int'(vt[i].a_v), vt[i].a_cbr, int'(vt[i].a_cbt),
                   vt[i].l_en, int'(vt[i].l_q), int'(vt[i].l_v));
            step();
            chk($sformatf("vec%0d_en", i), bus.cdb_en_o, vt[i].x_en);
            if (vt[i].x_en) begin
                chk($sformatf("vec%0d_src", i), bus.cdb_src_o, vt[i].x_src);
                chk($sformatf("vec%0d_q", i), bus.cdb_q_o, vt[i].x_q);
            end
        end
        en  = 1'b1;
        clr = 1'b0;
        idle();

        // Sustained dual load with producers honouring stall.
        reset_dut();
        na = 0;
        nl = 0;
        for (int c = 0; c < 40; c++) begin
            set_in((na < 8) && !bus.alu_stall_o, na, 'h100 + na, na[0], 'h40 + na,
                   (nl < 8) && !bus.lsb_stall_o, 8 + nl, 'h200 + nl);
            if (bus.alu_en_i) na++;
            if (bus.lsb_en_i) nl++;
            step();
        end
        idle();
        chk("dual_count", bc_log.size(), 16);
        chk("dual_ovf", ovf, 0);
        nb = (bc_log.size() < 16) ? bc_log.size() : 16;
        for (int i = 0; i < nb; i++)
            chk($sformatf("dual_order%0d", i), bc_log[i], {i[0], ROB_BIT'((i % 2) ? 8 + i / 2 : i / 2)});

        // Both sources pushing every edge ignoring stall: the LSB FIFO fills and overflows.
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            set_in(1, i, 'h300 + i, 0, 0, 1, 16 + i, 'h400 + i);
            step();
            if (i == 3) chk("fill_lsb_stall", bus.lsb_stall_o, 1);
            if (i == 6) chk("fill_ovf_before", ovf, 0);
            if (i == 7) chk("fill_ovf_set", ovf, 1);
        end
        idle();
        repeat (10) step();
        chk("ovf_sticky", ovf, 1);

        // Flush with 2 ALU and 3 LSB entries queued plus a new ALU push.
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            set_in(1, i, i, 0, 0, 1, 8 + i, i);
            step();
        end
        clr = 1'b1;
        set_in(1, 20, 'h99, 1, 'h7, 0, 0, 0);
        step();
        clr = 1'b0;
        idle();
        chk("clr_cdb_en", bus.cdb_en_o, 0);
        chk("clr_stalls", {bus.alu_stall_o, bus.lsb_stall_o}, 0);
        nb = bc_log.size();
        repeat (5) step();
        chk("clr_no_stale", bc_log.size(), nb);

        // Asynchronous reset between edges while a broadcast is on the bus.
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 4 + i, 'h500 + i, 1, 'h20, 1, 12 + i, 'h600 + i);
            step();
        end
        idle();
        chk("pre_arst_en", bus.cdb_en_o, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_cdb_en", bus.cdb_en_o, 0);
        chk("arst_cdb_q", bus.cdb_q_o, 0);
        chk("arst_cdb_v", bus.cdb_v_o, 0);
        chk("arst_cdb_cbr", bus.cdb_cbr_o, 0);
        chk("arst_cdb_cbt", bus.cdb_cbt_o, 0);
        chk("arst_cdb_src", bus.cdb_src_o, 0);
        chk("arst_stalls", {bus.alu_stall_o, bus.lsb_stall_o}, 0);
        model_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        set_in(1, 1, 'h11, 0, 0, 1, 2, 'h22);
        step();
        idle();
        step();
        chk("arst_first_tie_src", bus.cdb_src_o, 0);
        chk("arst_first_tie_q", bus.cdb_q_o, 1);
        step();
        chk("arst_second_src", bus.cdb_src_o, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
